// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared encodings for the multi-cycle CPU control unit
package cpu_ctrl_pkg;

  localparam int TIMEOUT_CYCLES_DEFAULT = 16;

  typedef enum logic [2:0] {
    OP_RTYPE = 3'b000,
    OP_ADDI  = 3'b001,
    OP_LW    = 3'b010,
    OP_SW    = 3'b011,
    OP_BEQ   = 3'b100,
    OP_JMP   = 3'b101,
    OP_RSVD  = 3'b110,
    OP_HALT  = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_ERR    = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    PC_INC    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10
  } pc_sel_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  localparam logic WB_ALU = 1'b0;
  localparam logic WB_MEM = 1'b1;
  localparam logic DST_RD = 1'b0;
  localparam logic DST_RB = 1'b1;

  // ALU setup {alu_op, alu_src} for an opcode; WB reuses it so operands stay stable.
  function automatic logic [2:0] exec_alu(input opcode_e opc, input logic [1:0] alufn);
    logic [2:0] r;
    r = {ALU_ADD, 1'b0};
    case (opc)
      OP_RTYPE: r = {alufn, 1'b0};
      OP_ADDI,
      OP_LW,
      OP_SW:    r = {ALU_ADD, 1'b1};
      OP_BEQ:   r = {ALU_SUB, 1'b0};
      default:  r = {ALU_ADD, 1'b0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - saturating memory wait counter with timeout pulse
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wait_i,
  input  logic clear_i,
  output logic timeout_o
);

  localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Count stalled cycles; any handshake or state change restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !wait_i) begin
      cnt_d = 8'd0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = wait_i && (cnt_q == LAST);

endmodule

// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - multi-cycle control sequencer for the 16-bit CPU
module control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] opfn,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       mem_re,
  output logic       mem_we,
  output logic       addr_sel,
  output logic [1:0] alu_op,
  output logic       alu_src,
  output logic       reg_we,
  output logic       wb_sel,
  output logic       dst_sel,
  output logic       halted,
  output logic       err,
  output logic [2:0] state
);

  state_e     state_q;
  state_e     state_d;
  opcode_e    opc;
  logic [1:0] alufn;
  logic       mem_wait;
  logic       timeout;

  assign opc   = opcode_e'(opfn[4:2]);
  assign alufn = opfn[1:0];
  assign state = state_q;

  // Memory-facing states stall while the handshake is outstanding.
  assign mem_wait = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready;

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .wait_i   (mem_wait),
    .clear_i  (state_d != state_q),
    .timeout_o(timeout)
  );

  // State register; reset returns to IDLE and drops every strobe at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d  = state_q;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PC_INC;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    alu_op   = ALU_ADD;
    alu_src  = 1'b0;
    reg_we   = 1'b0;
    wb_sel   = WB_ALU;
    dst_sel  = DST_RD;
    halted   = 1'b0;
    err      = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;

      ST_FETCH: begin
        mem_re = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          pc_sel  = PC_INC;
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_ERR;
        end
      end

      ST_DECODE: begin
        case (opc)
          OP_JMP: begin
            pc_we   = 1'b1;
            pc_sel  = PC_JUMP;
            state_d = ST_FETCH;
          end
          OP_HALT: state_d = ST_HALT;
          OP_RSVD: state_d = ST_FETCH;
          default: state_d = ST_EXEC;
        endcase
      end

      ST_EXEC: begin
        {alu_op, alu_src} = exec_alu(opc, alufn);
        case (opc)
          OP_RTYPE,
          OP_ADDI: state_d = ST_WB;
          OP_LW,
          OP_SW:   state_d = ST_MEM;
          OP_BEQ: begin
            pc_sel  = PC_BRANCH;
            pc_we   = zero;
            state_d = ST_FETCH;
          end
          default: state_d = ST_FETCH;
        endcase
      end

      ST_MEM: begin
        addr_sel = 1'b1;
        mem_re   = (opc == OP_LW);
        mem_we   = (opc == OP_SW);
        if (mem_ready) begin
          state_d = (opc == OP_LW) ? ST_WB : ST_FETCH;
        end else if (timeout) begin
          state_d = ST_ERR;
        end
      end

      ST_WB: begin
        {alu_op, alu_src} = exec_alu(opc, alufn);
        reg_we  = 1'b1;
        wb_sel  = (opc == OP_LW) ? WB_MEM : WB_ALU;
        dst_sel = (opc == OP_RTYPE) ? DST_RD : DST_RB;
        state_d = ST_FETCH;
      end

      ST_HALT: halted = 1'b1;

      ST_ERR: err = 1'b1;

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// tb/tb_control_fsm.sv - randomized self-checking bench for control_fsm
module tb_control_fsm;

  localparam int TO = 4;

  typedef struct packed {
    logic [2:0] st;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       mem_re;
    logic       mem_we;
    logic       addr_sel;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_we;
    logic       wb_sel;
    logic       dst_sel;
    logic       halted;
    logic       err;
  } ctl_t;

  typedef struct {
    logic       mr;
    logic       z;
    logic [4:0] op;
    ctl_t       exp;
  } cyc_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] opfn = 5'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       ir_we, pc_we, mem_re, mem_we, addr_sel, alu_src, reg_we;
  logic       wb_sel, dst_sel, halted, err;
  logic [1:0] pc_sel, alu_op;
  logic [2:0] state;

  cyc_t sched[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc_no = 0;

  always #5 clk = ~clk;

  control_fsm #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opfn(opfn), .zero(zero), .mem_ready(mem_ready),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .mem_re(mem_re), .mem_we(mem_we),
    .addr_sel(addr_sel), .alu_op(alu_op), .alu_src(alu_src), .reg_we(reg_we),
    .wb_sel(wb_sel), .dst_sel(dst_sel), .halted(halted), .err(err), .state(state)
  );

  function automatic ctl_t observed();
    return ctl_t'({state, ir_we, pc_we, pc_sel, mem_re, mem_we, addr_sel,
                   alu_op, alu_src, reg_we, wb_sel, dst_sel, halted, err});
  endfunction

  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [4:0] rop();
    return 5'($urandom_range(0, 31));
  endfunction

  // Baseline outputs of a state with no strobes.
  function automatic ctl_t quiet(input logic [2:0] st);
    ctl_t c;
    c = '0;
    c.st = st;
    c.halted = (st == 3'd6);
    c.err = (st == 3'd7);
    return c;
  endfunction

  // Mostly legal stalls, sometimes long enough to trap.
  function automatic int rwait();
    if ($urandom_range(0, 9) < 8) return $urandom_range(0, TO - 1);
    return $urandom_range(TO, TO + 1);
  endfunction

  task automatic push(input logic mr, input logic z, input logic [4:0] op, input ctl_t e);
    cyc_t r;
    r.mr = mr;
    r.z = z;
    r.op = op;
    r.exp = e;
    sched.push_back(r);
  endtask

  task automatic sticky(input logic [2:0] st);
    for (int i = 0; i < 3; i++) push(rbit(), rbit(), rop(), quiet(st));
  endtask

  // Expand one instruction into its expected cycle-by-cycle trace.
  task automatic build(input logic [4:0] op, input int fw, input int mw, input logic z,
                       output bit term);
    ctl_t e;
    logic [2:0] opc;
    logic [1:0] a_op;
    logic a_src;
    opc = op[4:2];
    term = 0;
    for (int i = 0; i < fw && i < TO; i++) begin
      e = quiet(3'd1); e.mem_re = 1'b1;
      push(1'b0, rbit(), rop(), e);
    end
    if (fw >= TO) begin term = 1; sticky(3'd7); return; end
    e = quiet(3'd1); e.mem_re = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1;
    push(1'b1, rbit(), rop(), e);

    e = quiet(3'd2);
    if (opc == 3'd5) begin e.pc_we = 1'b1; e.pc_sel = 2'b10; end
    push(rbit(), rbit(), op, e);
    if (opc == 3'd7) begin term = 1; sticky(3'd6); return; end
    if (opc == 3'd5 || opc == 3'd6) return;

    a_op = (opc == 3'd0) ? op[1:0] : (opc == 3'd4) ? 2'b01 : 2'b00;
    a_src = (opc == 3'd1 || opc == 3'd2 || opc == 3'd3);
    e = quiet(3'd3); e.alu_op = a_op; e.alu_src = a_src;
    if (opc == 3'd4) begin e.pc_sel = 2'b01; e.pc_we = z; end
    push(rbit(), (opc == 3'd4) ? z : rbit(), op, e);
    if (opc == 3'd4) return;

    if (opc == 3'd2 || opc == 3'd3) begin
      e = quiet(3'd4); e.addr_sel = 1'b1;
      e.mem_re = (opc == 3'd2); e.mem_we = (opc == 3'd3);
      for (int i = 0; i < mw && i < TO; i++) push(1'b0, rbit(), op, e);
      if (mw >= TO) begin term = 1; sticky(3'd7); return; end
      push(1'b1, rbit(), op, e);
      if (opc == 3'd3) return;
    end

    e = quiet(3'd5); e.reg_we = 1'b1; e.alu_op = a_op; e.alu_src = a_src;
    e.wb_sel = (opc == 3'd2); e.dst_sel = (opc != 3'd0);
    push(rbit(), rbit(), op, e);
  endtask

  task automatic play(input int n);
    cyc_t r;
    for (int i = 0; i < n && sched.size() > 0; i++) begin
      r = sched.pop_front();
      mem_ready = r.mr; zero = r.z; opfn = r.op;
      #2;
      check($sformatf("cyc%0d st%0d", cyc_no, r.exp.st), observed(), r.exp);
      cyc_no++;
      @(posedge clk); #1;
    end
  endtask

  // Reset, then leave the bench at posedge+1 with an IDLE cycle queued.
  task automatic session_begin();
    @(negedge clk);
    rst_n = 1'b0; mem_ready = rbit(); zero = rbit(); opfn = rop();
    #2 check("rst_async", observed(), quiet(3'd0));
    @(posedge clk); #1;
    check("rst_hold", observed(), quiet(3'd0));
    rst_n = 1'b1;
    sched.delete();
    push(rbit(), rbit(), rop(), quiet(3'd0));
  endtask

  initial begin
    bit term;
    cyc_t r;

    session_begin();
    build(5'b00001, 0, 0, 1'b0, term);
    build(5'b01000, 0, 3, 1'b0, term);
    build(5'b10000, 0, 0, 1'b1, term);
    build(5'b10000, 0, 0, 1'b0, term);
    build(5'b00100, 3, 0, 1'b0, term);
    build(5'b10100, 1, 0, 1'b0, term);
    build(5'b11000, 0, 0, 1'b0, term);
    build(5'b01100, 2, 3, 1'b0, term);
    build(5'b11100, 0, 0, 1'b0, term);
    play(sched.size());

    session_begin();
    build(5'b00010, TO, 0, 1'b0, term);
    play(sched.size());

    session_begin();
    build(5'b01000, 0, TO, 1'b0, term);
    play(sched.size());

    session_begin();
    build(5'b01100, 0, 2, 1'b0, term);
    play(4);
    r = sched.pop_front();
    mem_ready = r.mr; zero = r.z; opfn = r.op;
    #2 check("sw_mem", observed(), r.exp);
    rst_n = 1'b0;
    #1 check("rst_mid_mem", observed(), quiet(3'd0));

    for (int s = 0; s < 40; s++) begin
      session_begin();
      term = 0;
      for (int k = 0; k < 8 && !term; k++) build(rop(), rwait(), rwait(), rbit(), term);
      play(sched.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
# control_fsm

Multi-cycle control unit for the 16-bit CPU. It sits beside the instruction decoder, takes the decoder's 5-bit `opfn` (opcode plus ALU function) and the ALU zero flag, and sequences the datapath through fetch, decode, execute, memory and writeback. It drives register-file, PC, IR and memory strobes, and handshakes with a variable-latency memory through `mem_ready`. A timeout traps a memory that never responds.

## Interface

- `TIMEOUT_CYCLES`, default 16: consecutive `mem_ready=0` cycles in FETCH/MEM before trapping to ERR. Legal range is 2–255.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `opfn` in 5: `{opcode[2:0], alufn[1:0]}` from the decoder. `alufn` is only meaningful when opcode=000.
- `zero` in 1: ALU zero flag, sampled in EXEC.
- `mem_ready` in 1: memory handshake. It completes the outstanding `mem_re`/`mem_we` in the same cycle.
- `ir_we` out 1: instruction register load.
- `pc_we` out 1: PC load.
- `pc_sel` out 2: PC source. 00 = pc+1, 01 = pc+sext(immi), 10 = zext(immj).
- `mem_re`, `mem_we` out 1 each: memory read and write strobes.
- `addr_sel` out 1: memory address source. 0 = PC, 1 = ALU result.
- `alu_op` out 2: 00 add, 01 sub, 10 and, 11 or.
- `alu_src` out 1: ALU operand B. 0 = reg[rb], 1 = sext(immi).
- `reg_we` out 1: register-file write.
- `wb_sel` out 1: writeback data. 0 = ALU, 1 = memory.
- `dst_sel` out 1: writeback destination. 0 = rd, 1 = rb.
- `halted` out 1: high in HALT.
- `err` out 1: high in ERR.
- `state` out 3: current state, for debug.

## Operation

Opcodes:
- 000 R-type (`alu_op=alufn`)
- 001 addi
- 010 lw
- 011 sw
- 100 beq
- 101 jmp
- 110 reserved (treated as a no-op)
- 111 halt

States and outputs:
- IDLE=0: all outputs 0. Goes to FETCH unconditionally.
- FETCH=1: `mem_re=1`, `addr_sel=0`.
  - When `mem_ready=1`: `ir_we=1`, `pc_we=1`, `pc_sel=00`, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE=2: the IR is stable and `opfn` is valid.
  - jmp: `pc_we=1`, `pc_sel=10`, then FETCH.
  - halt: go to HALT.
  - reserved: go to FETCH.
  - All other opcodes: go to EXEC.
- EXEC=3:
  - R-type: `alu_src=0`, then WB.
  - addi: `alu_op=00`, `alu_src=1`, then WB.
  - lw/sw: `alu_op=00`, `alu_src=1` (address = ra+immi), then MEM.
  - beq: `alu_op=01`, `alu_src=0`. If `zero=1`, assert `pc_we=1`, `pc_sel=01`. Then FETCH.
- MEM=4: `addr_sel=1`; `mem_re=1` for lw, `mem_we=1` for sw.
  - On `mem_ready=1`: lw goes to WB, sw goes to FETCH.
  - Otherwise stay in MEM.
- WB=5: `reg_we=1`; ALU/address operands stay as in EXEC.
  - R-type: `wb_sel=0`, `dst_sel=0`.
  - addi: `wb_sel=0`, `dst_sel=1`.
  - lw: `wb_sel=1`, `dst_sel=1`.
  - Then FETCH.
- HALT=6: all strobes 0, `halted=1`. Sticky until reset.
- ERR=7: all strobes 0, `err=1`. Sticky until reset.

Output encoding:
- Outputs are a Moore decode of `state` and `opfn`.
- The exceptions are `ir_we`, `pc_we` and the branch `pc_we`, which are also qualified by `mem_ready`/`zero` in the same cycle.
- In every output, bits not listed for a state are 0.

Timeout:
- The wait counter increments on each FETCH/MEM cycle with `mem_ready=0`.
- It clears on `mem_ready=1` and on any state change.
- When the count reaches `TIMEOUT_CYCLES-1` and `mem_ready` is still 0, the next state is ERR.
- If `mem_ready=1` arrives in the same cycle as the timeout, the handshake wins.

## Timing

- Reset: `state=IDLE`, counter 0, all outputs 0. Assertion is asynchronous at any point, including mid-MEM with `mem_we` high, and drops all strobes immediately.
- Release: first rising edge enters IDLE→FETCH. `mem_re` rises one cycle after reset release.
- Latency with zero-wait memory:

| Instruction | Cycles |
|---|---|
| jmp | 2 |
| beq | 3 |
| sw | 4 |
| R-type / addi | 4 |
| lw | 5 |

- Each `mem_ready=0` cycle in FETCH or MEM adds one cycle.
- `mem_re` and `mem_we` are never high together.
- `pc_we` fires at most once per state visit.

## Structure

- Shared package `cpu_ctrl_pkg` holds:
  - opcode constants,
  - state encoding,
  - `pc_sel`, `alu_op`, `wb_sel` and `dst_sel` encodings,
  - the default `TIMEOUT_CYCLES`.
- Sub-module `mem_wait_timer` contains the saturating counter and produces a `timeout` pulse.
- The main FSM is a two-process design: a registered state plus a combinational next-state/output block.

## Test plan

1. **Reset and R-type:** reset, then fetch an R-type sub (`opfn=00001`) with `mem_ready` tied 1.
   - `state` goes 0,1,2,3,5,1.
   - `alu_op=01` in EXEC.
   - `reg_we=1` only in WB with `dst_sel=0`.
2. **lw with wait states:** `opfn=01000`, `mem_ready` held low for 3 cycles in MEM.
   - `mem_re`/`addr_sel=1` held for 4 cycles.
   - WB has `wb_sel=1`.
   - 8 cycles total.
3. **beq taken and not taken:**
   - `zero=1` in EXEC → `pc_we=1`, `pc_sel=01`.
   - `zero=0` → `pc_we=0`.
   - Both return to FETCH after 3 cycles.
4. **Timeout:** with `TIMEOUT_CYCLES=4`, hold `mem_ready=0` in FETCH.
   - ERR is entered after 4 wait cycles and `err=1` is sticky.
   - A repeat where `mem_ready=1` arrives on the 4th cycle goes to DECODE instead.
5. **Halt and mid-transaction reset:**
   - `opfn=11100` → HALT with `halted=1`; `mem_ready` pulses are ignored.
   - Asserting `rst_n=0` mid-MEM of an sw clears `mem_we` asynchronously, before the next clock edge, and returns to IDLE.
